// File: rtl/csr_access_pkg.sv
// csr_access_pkg: shared types for the mem1 CSR access stage
package csr_access_pkg;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } csr_acc_state_t;

  typedef enum logic [3:0] {
    IMISALIGN  = 4'd0,
    IFAULT     = 4'd1,
    IILLEGAL   = 4'd2,
    BREAKPOINT = 4'd3
  } ecause_t;

endpackage

// File: rtl/csr_access.sv
// csr_access: mem1-stage CSR port initiator; CSR_SERIALIZE_EN enables draining writeback before the access
module csr_access
  import csr_access_pkg::*;
(
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [1:0]  ex_csr_op,
  input  logic [11:0] ex_csr_addr,
  input  logic [31:0] ex_csr_src,
  input  logic        ex_src_zero,
  input  logic [31:0] ex_insn,
  input  logic [29:0] ex_pc,
  output logic        m1_stall,
  output logic [11:0] mem1_csr_addr,
  output logic [1:0]  mem1_csr_write,
  output logic [31:0] mem1_csr_din,
  input  logic        csr_error,
  input  logic        csr_flush,
  input  logic [31:0] csr_dout,
  input  logic        csr_kill,
  input  logic        wb_busy,
  input  logic        wb_stall,
  output logic        m1_valid,
  output logic        m1_exc,
  output ecause_t     m1_exc_cause,
  output logic        m1_flush,
  output logic [29:0] m1_pc,
  output logic [31:0] m1_data
);

`ifdef CSR_SERIALIZE_EN
  localparam csr_acc_state_t ACC_NEXT = DRAIN;
`else
  localparam csr_acc_state_t ACC_NEXT = ACCESS;
`endif

  csr_acc_state_t state_q, state_d;
  csr_op_t        op_q, op_d;
  logic [11:0]    addr_q, addr_d;
  logic [31:0]    src_q, src_d, insn_q, insn_d, data_q, data_d;
  logic           zero_q, zero_d, exc_q, exc_d, flush_q, flush_d;
  logic [29:0]    pc_q, pc_d, rpc_q, rpc_d;
  logic           accept;

  // set/clear with a zero operand only reads, so it must not touch the CSR
  function automatic csr_op_t wr_code(csr_op_t op, logic zero);
    return (op != CSR_RW && zero) ? CSR_NONE : op;
  endfunction

  assign accept         = state_q == IDLE && ex_valid && !csr_kill;
  assign m1_stall       = state_q != IDLE;
  assign mem1_csr_addr  = addr_q;
  assign mem1_csr_din   = src_q;
  assign mem1_csr_write = (state_q == ACCESS && !csr_kill) ? wr_code(op_q, zero_q) : CSR_NONE;
  assign m1_valid       = state_q == HOLD && !csr_kill;
  assign m1_exc         = exc_q;
  assign m1_exc_cause   = IILLEGAL;
  assign m1_flush       = flush_q;
  assign m1_pc          = rpc_q;
  assign m1_data        = data_q;

  // next state, operand capture on accept and result capture at the end of the access
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = accept ? ex_csr_addr : addr_q;
    src_d   = accept ? ex_csr_src : src_q;
    zero_d  = accept ? ex_src_zero : zero_q;
    insn_d  = accept ? ex_insn : insn_q;
    pc_d    = accept ? ex_pc : pc_q;
    exc_d   = exc_q;
    flush_d = flush_q;
    data_d  = data_q;
    rpc_d   = rpc_q;
    if (accept) begin
      op_d    = csr_op_t'(ex_csr_op);
      state_d = ACC_NEXT;
    end
    if (state_q == DRAIN) state_d = csr_kill ? IDLE : (wb_busy ? DRAIN : ACCESS);
    if (state_q == ACCESS) begin
      state_d = csr_kill ? IDLE : HOLD;
      if (!csr_kill) begin
        exc_d   = csr_error;
        flush_d = csr_flush & ~csr_error;
        data_d  = csr_error ? insn_q : csr_dout;
        rpc_d   = (csr_flush & ~csr_error) ? pc_q + 30'd1 : pc_q;
      end
    end
    if (state_q == HOLD) state_d = (csr_kill || !wb_stall) ? IDLE : HOLD;
  end

  // state and registered outputs
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= CSR_NONE;
      addr_q  <= '0;
      src_q   <= '0;
      zero_q  <= 1'b0;
      insn_q  <= '0;
      pc_q    <= '0;
      exc_q   <= 1'b0;
      flush_q <= 1'b0;
      data_q  <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      zero_q  <= zero_d;
      insn_q  <= insn_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
      flush_q <= flush_d;
      data_q  <= data_d;
      rpc_q   <= rpc_d;
    end
  end

endmodule

// File: tb/tb_csr_access.sv
// tb_csr_access: randomized self-checking bench for csr_access against a transaction-level model
module tb_csr_access;
  import csr_access_pkg::*;

  logic        clk_core = 1'b0;
  logic        reset_n, ex_valid, ex_src_zero, csr_error, csr_flush, csr_kill, wb_busy, wb_stall;
  logic [1:0]  ex_csr_op;
  logic [11:0] ex_csr_addr;
  logic [31:0] ex_csr_src, ex_insn, csr_dout;
  logic [29:0] ex_pc;
  logic        m1_stall, m1_valid, m1_exc, m1_flush;
  logic [11:0] mem1_csr_addr;
  logic [1:0]  mem1_csr_write;
  logic [31:0] mem1_csr_din, m1_data;
  logic [29:0] m1_pc;
  ecause_t     m1_exc_cause;

  int checks = 0;
  int errors = 0;
  logic [11:0] last_addr = '0;

  always #5 clk_core = ~clk_core;

  csr_access dut (
    .clk_core(clk_core), .reset_n(reset_n), .ex_valid(ex_valid), .ex_csr_op(ex_csr_op),
    .ex_csr_addr(ex_csr_addr), .ex_csr_src(ex_csr_src), .ex_src_zero(ex_src_zero),
    .ex_insn(ex_insn), .ex_pc(ex_pc), .m1_stall(m1_stall), .mem1_csr_addr(mem1_csr_addr),
    .mem1_csr_write(mem1_csr_write), .mem1_csr_din(mem1_csr_din), .csr_error(csr_error),
    .csr_flush(csr_flush), .csr_dout(csr_dout), .csr_kill(csr_kill), .wb_busy(wb_busy),
    .wb_stall(wb_stall), .m1_valid(m1_valid), .m1_exc(m1_exc), .m1_exc_cause(m1_exc_cause),
    .m1_flush(m1_flush), .m1_pc(m1_pc), .m1_data(m1_data)
  );

  task automatic scramble_ex();
    ex_csr_op   = 2'($urandom_range(1, 3));
    ex_csr_addr = 12'($urandom);
    ex_csr_src  = $urandom;
    ex_src_zero = 1'($urandom);
    ex_insn     = $urandom;
    ex_pc       = 30'($urandom);
  endtask

  task automatic scramble_port();
    csr_error = 1'($urandom);
    csr_flush = 1'($urandom);
    csr_dout  = $urandom;
  endtask

  // one CSR instruction from accept to retirement; entered and left just after a falling edge in IDLE
  task automatic run_txn(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src,
                         input logic zero, input logic [31:0] insn, input logic [29:0] pc,
                         input int busy, input int stall, input bit kill,
                         input logic err, input logic fl, input logic [31:0] dout);
    logic [1:0]  ew;
    logic [31:0] ed;
    logic        ef;
    logic [29:0] ep;
    ew = ((op == 2'b10 || op == 2'b11) && zero) ? 2'b00 : op;
    ef = fl & ~err;
    ed = err ? insn : dout;
    ep = ef ? pc + 30'd1 : pc;
    ex_valid = 1'b1; ex_csr_op = op; ex_csr_addr = addr; ex_csr_src = src;
    ex_src_zero = zero; ex_insn = insn; ex_pc = pc;
    csr_kill = 1'b0; wb_stall = 1'b0; wb_busy = busy > 0;
    scramble_port();
    #1;
    checks++;
    if (m1_stall !== 1'b0) begin errors++; $display("FAIL accept_stall got %b exp 0", m1_stall); end
    @(negedge clk_core);
    ex_valid = 1'b0;
    scramble_ex();
    last_addr = addr;
`ifdef CSR_SERIALIZE_EN
    for (int i = 0; i <= busy; i++) begin
      wb_busy = i < busy;
      #1;
      checks++;
      if ({m1_stall, m1_valid, mem1_csr_write} !== 4'b1000) begin
        errors++; $display("FAIL drain got stall/valid/write %b exp 1000", {m1_stall, m1_valid, mem1_csr_write});
      end
      @(negedge clk_core);
    end
`endif
    wb_busy = 1'($urandom);
    csr_dout = dout; csr_error = err; csr_flush = fl; csr_kill = kill;
    #1;
    checks++;
    if ({mem1_csr_write, mem1_csr_addr, mem1_csr_din, m1_valid, m1_stall} !== {kill ? 2'b00 : ew, addr, src, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL access got write=%b addr=%h din=%h valid=%b stall=%b exp write=%b addr=%h din=%h valid=0 stall=1",
               mem1_csr_write, mem1_csr_addr, mem1_csr_din, m1_valid, m1_stall, kill ? 2'b00 : ew, addr, src);
    end
    @(negedge clk_core);
    csr_kill = 1'b0; wb_busy = 1'b0;
    scramble_port();
    if (!kill) begin
      for (int i = 0; i <= stall; i++) begin
        wb_stall = i < stall;
        #1;
        checks++;
        if ({m1_valid, m1_exc, m1_flush, m1_pc, m1_data, m1_exc_cause, mem1_csr_write, m1_stall} !==
            {1'b1, err, ef, ep, ed, IILLEGAL, 2'b00, 1'b1}) begin
          errors++;
          $display("FAIL hold got valid=%b exc=%b flush=%b pc=%h data=%h cause=%0d write=%b stall=%b exp 1 %b %b %h %h 2 00 1",
                   m1_valid, m1_exc, m1_flush, m1_pc, m1_data, m1_exc_cause, mem1_csr_write, m1_stall, err, ef, ep, ed);
        end
        scramble_port();
        @(negedge clk_core);
      end
      wb_stall = 1'b0;
    end
    #1;
    checks++;
    if ({m1_stall, m1_valid} !== 2'b00) begin
      errors++; $display("FAIL back_to_idle got stall/valid %b exp 00", {m1_stall, m1_valid});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ex_valid = 1'b1; csr_kill = 1'b0; wb_busy = 1'b0; wb_stall = 1'b0;
    scramble_ex();
    scramble_port();
    repeat (2) @(negedge clk_core);
    checks++;
    if ({m1_valid, m1_exc, m1_flush, m1_data, m1_pc, mem1_csr_write, mem1_csr_addr, mem1_csr_din, m1_stall} !== '0
        || m1_exc_cause !== IILLEGAL) begin
      errors++;
      $display("FAIL reset_values got valid=%b exc=%b flush=%b data=%h pc=%h write=%b addr=%h din=%h stall=%b cause=%0d exp all 0 cause 2",
               m1_valid, m1_exc, m1_flush, m1_data, m1_pc, mem1_csr_write, mem1_csr_addr, mem1_csr_din, m1_stall, m1_exc_cause);
    end
    reset_n = 1'b1;
    ex_csr_addr = 12'h123;
    @(negedge clk_core);
    ex_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk_core);
    checks++;
    if ({m1_stall, m1_valid, mem1_csr_addr} !== 14'd0) begin
      errors++; $display("FAIL reset_midflight got stall=%b valid=%b addr=%h exp 0 0 000", m1_stall, m1_valid, mem1_csr_addr);
    end
    reset_n = 1'b1;
    last_addr = '0;
    @(negedge clk_core);
  endtask

  task automatic test_directed();
    run_txn(2'b01, 12'h340, 32'hDEADBEEF, 1'b0, 32'h34001073, 30'h10, 0, 0, 0, 1'b0, 1'b0, 32'h0);
    run_txn(2'b10, 12'h300, 32'h0, 1'b1, 32'h30002073, 30'h11, 0, 0, 0, 1'b0, 1'b0, 32'h00001800);
    run_txn(2'b01, 12'hC00, 32'h5, 1'b0, 32'hC0001073, 30'h12, 0, 0, 0, 1'b1, 1'b1, 32'h77);
    run_txn(2'b01, 12'h180, 32'h8000_0000, 1'b0, 32'h18001073, 30'h40, 0, 0, 0, 1'b0, 1'b1, 32'h0);
    run_txn(2'b11, 12'h344, 32'h80, 1'b0, 32'h34403073, 30'h3FFFFFFF, 0, 0, 0, 1'b0, 1'b1, 32'h88);
    run_txn(2'b11, 12'h344, 32'h0, 1'b1, 32'h34403073, 30'h20, 1, 0, 0, 1'b0, 1'b0, 32'h99);
  endtask

  task automatic test_kill();
    run_txn(2'b01, 12'h340, 32'h1234, 1'b0, 32'h34001073, 30'h50, 3, 0, 1, 1'b0, 1'b0, 32'h5);
  endtask

  task automatic test_idle_kill();
    ex_valid = 1'b1; csr_kill = 1'b1;
    scramble_ex();
    ex_csr_addr = ~last_addr;
    #1;
    checks++;
    if (m1_stall !== 1'b0) begin errors++; $display("FAIL idle_kill_stall got %b exp 0", m1_stall); end
    @(negedge clk_core);
    ex_valid = 1'b0; csr_kill = 1'b0;
    #1;
    checks++;
    if ({m1_stall, mem1_csr_addr} !== {1'b0, last_addr}) begin
      errors++; $display("FAIL idle_kill_capture got stall=%b addr=%h exp 0 %h", m1_stall, mem1_csr_addr, last_addr);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(2'b01, 12'h340, 32'hCAFEF00D, 1'b0, 32'h11111111, 30'h60, 0, 4, 0, 1'b0, 1'b0, 32'hDEADBEEF);
    run_txn(2'b10, 12'h341, 32'h4, 1'b0, 32'h22222222, 30'h61, 0, 0, 0, 1'b0, 1'b0, 32'h100);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      op = 2'($urandom_range(1, 3));
      run_txn(op, 12'($urandom), $urandom, 1'($urandom), $urandom, 30'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_kill();
    test_idle_kill();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
